alu: RTL and testbench

Registered 32-bit integer ALU for the CPU execute stage. It takes the first operand (Rn), the shifted second operand (Op2) and the current carry flag. It performs one of 16 ARM-style data-processing operations selected by a 4-bit opcode. The result and the C/N/Z/V flags are registered on the next clock edge for writeback and flag update.

---
 rtl/alu.sv | 91 +++++++++
 tb/tb_alu.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit ARM-style ALU: 16 data-processing ops through one shared 33-bit adder,
// with the result and C/N/Z/V flags captured on the rising clock edge.
package alu_pkg;
  localparam int unsigned WordWidth = 32;

  localparam logic [3:0] ALUType_And = 4'h0;
  localparam logic [3:0] ALUType_Eor = 4'h1;
  localparam logic [3:0] ALUType_Sub = 4'h2;
  localparam logic [3:0] ALUType_Rsb = 4'h3;
  localparam logic [3:0] ALUType_Add = 4'h4;
  localparam logic [3:0] ALUType_Adc = 4'h5;
  localparam logic [3:0] ALUType_Sbc = 4'h6;
  localparam logic [3:0] ALUType_Rsc = 4'h7;
  localparam logic [3:0] ALUType_Tst = 4'h8;
  localparam logic [3:0] ALUType_Teq = 4'h9;
  localparam logic [3:0] ALUType_Cmp = 4'hA;
  localparam logic [3:0] ALUType_Cmn = 4'hB;
  localparam logic [3:0] ALUType_Orr = 4'hC;
  localparam logic [3:0] ALUType_Mov = 4'hD;
  localparam logic [3:0] ALUType_Bic = 4'hE;
  localparam logic [3:0] ALUType_Mvn = 4'hF;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic [WordWidth-1:0] in_Rn,
  input  logic [WordWidth-1:0] in_Op2,
  input  logic                 in_Carry,
  input  logic [3:0]           in_Opcode,
  output logic [WordWidth-1:0] out_Y,
  output logic [3:0]           out_CNZV,
  input  logic                 in_Clk,
  input  logic                 in_Rst_n
);

  logic [WordWidth-1:0] add_a, add_b, logic_r, result;
  logic                 add_cin, is_arith;
  logic [WordWidth:0]   sum;
  logic                 c_d, n_d, z_d, v_d;
  logic [WordWidth-1:0] y_q;
  logic [3:0]           cnzv_q;

  always_comb begin
    add_a    = in_Rn;
    add_b    = in_Op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    logic_r  = '0;
    unique case (in_Opcode)
      ALUType_And, ALUType_Tst: begin is_arith = 1'b0; logic_r = in_Rn & in_Op2; end
      ALUType_Eor, ALUType_Teq: begin is_arith = 1'b0; logic_r = in_Rn ^ in_Op2; end
      ALUType_Sub, ALUType_Cmp: begin add_b = ~in_Op2; add_cin = 1'b1; end
      ALUType_Rsb: begin add_a = in_Op2; add_b = ~in_Rn; add_cin = 1'b1; end
      ALUType_Add, ALUType_Cmn: begin end
      ALUType_Adc: add_cin = in_Carry;
      ALUType_Sbc: begin add_b = ~in_Op2; add_cin = in_Carry; end
      ALUType_Rsc: begin add_a = in_Op2; add_b = ~in_Rn; add_cin = in_Carry; end
      ALUType_Orr: begin is_arith = 1'b0; logic_r = in_Rn | in_Op2; end
      ALUType_Mov: begin is_arith = 1'b0; logic_r = in_Op2; end
      ALUType_Bic: begin is_arith = 1'b0; logic_r = in_Rn & ~in_Op2; end
      ALUType_Mvn: begin is_arith = 1'b0; logic_r = ~in_Op2; end
      default: begin end
    endcase

    sum    = {1'b0, add_a} + {1'b0, add_b} + {{WordWidth{1'b0}}, add_cin};
    result = is_arith ? sum[WordWidth-1:0] : logic_r;

    // Logical ops take C from the shifter carry and leave V as last registered.
    c_d = is_arith ? sum[WordWidth] : in_Carry;
    v_d = is_arith ? ((add_a[WordWidth-1] == add_b[WordWidth-1]) &&
                      (sum[WordWidth-1] != add_a[WordWidth-1]))
                   : cnzv_q[0];
    n_d = result[WordWidth-1];
    z_d = (result == '0);
  end

  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      y_q    <= '0;
      cnzv_q <= 4'b0000;
    end else begin
      y_q    <= result;
      cnzv_q <= {c_d, n_d, z_d, v_d};
    end
  end

  assign out_Y    = y_q;
  assign out_CNZV = cnzv_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed results, a monitor checks them
// one cycle later; reset behaviour is checked directly between edges.
module tb_alu;
  logic [31:0] in_Rn, in_Op2, out_Y;
  logic        in_Carry, in_Clk, in_Rst_n;
  logic [3:0]  in_Opcode, out_CNZV;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    int          due;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  alu dut (
    .in_Rn    (in_Rn),
    .in_Op2   (in_Op2),
    .in_Carry (in_Carry),
    .in_Opcode(in_Opcode),
    .out_Y    (out_Y),
    .out_CNZV (out_CNZV),
    .in_Clk   (in_Clk),
    .in_Rst_n (in_Rst_n)
  );

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  always @(posedge in_Clk) cycle <= cycle + 1;

  // Monitor: each result is due on the edge after its inputs were driven.
  always @(posedge in_Clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      e = exp_q.pop_front();
      tests++;
      if (out_Y !== e.y || out_CNZV !== e.f) begin
        fails++;
        $display("FAIL %s: got Y=%08h CNZV=%04b, want Y=%08h CNZV=%04b",
                 e.nm, out_Y, out_CNZV, e.y, e.f);
      end
    end
  end

  task automatic drive(input logic [3:0] opc, input logic [31:0] rn, input logic [31:0] op2,
                       input logic c, input logic [31:0] ey, input logic [3:0] ef,
                       input string nm);
    exp_t e;
    @(negedge in_Clk);
    in_Opcode = opc;
    in_Rn     = rn;
    in_Op2    = op2;
    in_Carry  = c;
    e.y   = ey;
    e.f   = ef;
    e.due = cycle + 1;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [31:0] ey, input logic [3:0] ef);
    tests++;
    if (out_Y !== ey || out_CNZV !== ef) begin
      fails++;
      $display("FAIL %s: got Y=%08h CNZV=%04b, want Y=%08h CNZV=%04b",
               nm, out_Y, out_CNZV, ey, ef);
    end
  endtask

  logic [31:0] sw_y[16];
  logic [3:0]  sw_f[16];

  initial begin
    sw_y = '{32'h000F000F, 32'h0FF00FF0, 32'h0E100E10, 32'hF1EFF1F0,
             32'h100E100E, 32'h100E100F, 32'h0E100E10, 32'hF1EFF1F0,
             32'h000F000F, 32'h0FF00FF0, 32'h0E100E10, 32'h100E100E,
             32'h0FFF0FFF, 32'h00FF00FF, 32'h0F000F00, 32'hFF00FF00};
    sw_f = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0100,
             4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1100};

    in_Rst_n  = 1'b0;
    in_Rn     = 32'h2;
    in_Op2    = 32'h3;
    in_Carry  = 1'b0;
    in_Opcode = 4'h4;
    #1;
    check_now("reset_initial", 32'h0, 4'b0000);
    repeat (2) @(posedge in_Clk);
    #1;
    check_now("reset_held", 32'h0, 4'b0000);
    @(negedge in_Clk);
    in_Rst_n = 1'b1;

    // V after reset is 0, so a logical op must hold it at 0.
    drive(4'hF, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 4'b1100, "mvn_after_reset");
    drive(4'h4, 32'h2, 32'h3, 1'b0, 32'h00000005, 4'b0000, "add_2_3");
    drive(4'h4, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 4'b1010, "add_wrap");
    drive(4'h2, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 4'b1001, "sub_ovf");
    drive(4'hF, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 4'b0101, "mvn_vhold");
    drive(4'h6, 32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 4'b0100, "sbc_5_7");
    for (int i = 0; i < 16; i++)
      drive(i[3:0], 32'h0F0F0F0F, 32'h00FF00FF, 1'b1, sw_y[i], sw_f[i],
            $sformatf("sweep_op%0h", i));

    @(negedge in_Clk);
    // Reset between edges while an ADD is pending.
    in_Opcode = 4'h4;
    in_Rn     = 32'h2;
    in_Op2    = 32'h3;
    in_Carry  = 1'b0;
    #2;
    in_Rst_n = 1'b0;
    #1;
    check_now("reset_async", 32'h0, 4'b0000);
    repeat (2) @(posedge in_Clk);
    #1;
    check_now("reset_hold_edges", 32'h0, 4'b0000);
    @(negedge in_Clk);
    in_Rst_n = 1'b1;
    drive(4'h4, 32'h2, 32'h3, 1'b0, 32'h00000005, 4'b0000, "add_after_reset");
    drive(4'hD, 32'h0, 32'h80000000, 1'b0, 32'h80000000, 4'b0100, "mov_neg");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge in_Clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
